rs_age_select: RTL and testbench
================================

# rs_age_select

Parametrised reservation station for the out-of-order RV32 core. It sits between dispatch and a shared execution unit. Compared with the previous station it snoops `NUM_CDB` result broadcast channels instead of two fixed ones, applies a real `issue_ready` back-pressure handshake, supports flush, and reports occupancy. With age ordering compiled in, it issues the oldest ready entry first.

## Interface
Parameters:
- `RS_SIZE_BIT`, `` `RS_SIZE_BIT ``: log2 of entry count; depth = 2^RS_SIZE_BIT, minimum 1.
- `NUM_CDB`, 2: number of result broadcast channels snooped, minimum 1.
- `ROB_W`, `` `ROB_WIDTH_BIT ``: ROB tag width.
- `TYPE_W`, `` `RS_TYPE_BIT ``: operation-type width.

Ports:
- `clk_in`  in  1  clock.
- `rst_n_in`  in  1  reset; synchronous, active-low.
- `rdy_in`  in  1  global stall; low freezes all state.
- `flush`  in  1  misprediction flush.
- `inst_valid`  in  1  dispatch insert request.
- `inst_type`  in  TYPE_W  operation.
- `inst_rob_id`  in  ROB_W  destination tag.
- `inst_r1`, `inst_r2`  in  32  operand values, valid when the matching dependency flag is low.
- `inst_dep1`, `inst_dep2`  in  ROB_W  producer tags.
- `inst_has_dep1`, `inst_has_dep2`  in  1  operand pending.
- `cdb_valid`  in  NUM_CDB  per-channel broadcast valid.
- `cdb_rob_id`  in  NUM_CDB*ROB_W  flattened tags; channel k occupies bits [k*ROB_W +: ROB_W].
- `cdb_value`  in  NUM_CDB*32  flattened values.
- `full`  out  1  all entries busy.
- `count`  out  RS_SIZE_BIT+1  busy entries.
- `overflow`  out  1  sticky: an insert arrived while `full`.
- `issue_valid`  out  1  an entry is selected.
- `issue_ready`  in  1  execution unit accepts.
- `issue_type`  out  TYPE_W; `issue_rob_id`  out  ROB_W; `issue_r1`, `issue_r2`  out  32.

## Operation
- Entry fields: busy, rob_id, type, r1, r2, has_dep1/2, dep1/2.
- Reset (`rst_n_in` low at an edge, overrides everything): all entries not busy, `count`=0, `full`=0, `overflow`=0. Combinationally after reset, `issue_valid`=0 and the `issue_*` data outputs are 0.
- Insert: takes the lowest-index free entry. Operands are resolved at insert:
  - `!has_dep` takes the dispatch value.
  - Otherwise, if a valid CDB channel carries the matching tag, capture that value and clear the dependency.
  - Otherwise keep the dependency.
- Insert while `full`: the request is dropped and `overflow` is set until reset.
- Wakeup: for every busy entry with a pending operand, a valid CDB channel carrying the matching tag writes the value and clears the dependency at the edge.
- Operand priority: a free operand uses its stored value; otherwise the lowest-index matching CDB channel wins. Duplicate tags across channels are illegal.
- Ready(e) = busy and both operands are free, either stored or matching a CDB channel this cycle. An entry can therefore issue in the same cycle its last operand broadcasts; `issue_r*` are bypassed from the CDB.
- Select: see Configuration. `issue_valid` = some entry is ready AND `rdy_in` AND `!flush`.
- Issue handshake: when `issue_valid && issue_ready`, the selected entry is freed at the edge. When `issue_ready` is low, the entry stays and selection is re-evaluated next cycle. Outputs may change, so the execution unit samples only on the handshake.
- Flush: at the edge, all entries are cleared and `count` becomes 0. A same-cycle insert or issue is discarded. `overflow` is unaffected.
- `rdy_in` low: no state changes and `issue_valid`=0. CDB traffic in stalled cycles is lost; upstream guarantees none occurs.

## Timing
- Insert visible (busy, `count`) one cycle after `inst_valid`. Earliest issue is that following cycle.
- Wakeup to issue: 0 cycles when bypassed from the CDB.
- `full` and `count` are registered-state functions. `full` ignores a same-cycle issue, so dispatch must not insert when `full` is high.
- `count` next = count + accepted insert − handshake, or 0 on flush or reset.
- A simultaneous insert and issue of different entries are both honoured.

## Configuration
- `RS_AGE_ORDER_EN` defined:
  - Keep an age matrix. On insert of entry e, set older[e][j]=1 for every busy j. On freeing j, clear column j.
  - Select the ready entry with no ready older entry, i.e. the oldest ready entry.
- `RS_AGE_ORDER_EN` undefined: select the lowest-index ready entry. The matrix is not built.

## Structure
- `const.v` holds `RS_SIZE_BIT`, `RS_TYPE_BIT`, `ROB_WIDTH_BIT`, and a new `` `NUM_CDB `` default.
- One sub-module, `rs_pick`: takes the ready vector (plus the age matrix when enabled) and outputs a one-hot grant and an index.

## Test plan
- Reset, then insert an independent add (r1=5, r2=7, rob 3) with `issue_ready`=1: `issue_valid` one cycle later with rob 3 and values 5/7; `count` goes 1→0.
- Insert with has_dep1 on tag 9, then later `cdb_valid[1]` with tag 9 and value 0x1234: issue in the same cycle, `issue_r1`=0x1234.
- Insert in the same cycle that CDB channel 0 broadcasts the needed tag: the operand is captured and the entry issues next cycle with no extra wait.
- With `RS_AGE_ORDER_EN`: fill entries A, B, C in order, free A's slot, insert D into it, make all ready: issue order is B, C, D.
- Hold `issue_ready`=0 for 3 cycles with the station full, then insert: `overflow`=1, the request is dropped, `count` stays 2^RS_SIZE_BIT.
- Flush while 3 entries are busy and a concurrent insert occurs: `count`=0 next cycle and `issue_valid`=0.

Source files
------------

// File: rtl/rs_age_select_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rs_age_select_pkg
// Brief    : Shared types, build defaults and operand-source helper for the
//            rs_age_select reservation station.
// Revision : 1.0
// ============================================================================

`ifndef RS_SIZE_BIT
`define RS_SIZE_BIT 2
`endif
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif
`ifndef RS_TYPE_BIT
`define RS_TYPE_BIT 4
`endif
`ifndef NUM_CDB
`define NUM_CDB 2
`endif

package rs_age_select_pkg;

    localparam int DATA_W = 32;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] value;
    } cdb_hit_t;

    typedef enum logic [1:0] {
        OPND_STORED  = 2'd0,
        OPND_BYPASS  = 2'd1,
        OPND_PENDING = 2'd2
    } opnd_src_e;

    function automatic opnd_src_e opnd_src(input logic has_dep, input logic hit);
        if (!has_dep) begin
            return OPND_STORED;
        end else if (hit) begin
            return OPND_BYPASS;
        end else begin
            return OPND_PENDING;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/rs_pick.sv
`default_nettype none
// ============================================================================
// Module   : rs_pick
// Brief    : Issue selector. Lowest-index ready entry by default; with
//            RS_AGE_ORDER_EN defined, the oldest ready entry via an age matrix.
// Revision : 1.0
// ============================================================================

module rs_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     ready,
`ifdef RS_AGE_ORDER_EN
    input  logic [N*N-1:0]   older,
`endif
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] cand;

`ifdef RS_AGE_ORDER_EN
    // Row e of the matrix marks the entries older than e.
    for (genvar e = 0; e < N; e++) begin : g_age
        assign cand[e] = ready[e] && !(|(older[e*N +: N] & ready));
    end
`else
    assign cand = ready;
`endif

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int e = 0; e < N; e++) begin
            if (cand[e] && !any) begin
                any      = 1'b1;
                grant[e] = 1'b1;
                idx      = IDX_W'(e);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rs_age_select.sv
`default_nettype none
// ============================================================================
// Module   : rs_age_select
// Brief    : Reservation station with NUM_CDB-channel wakeup/bypass, issue
//            handshake, flush and occupancy. RS_AGE_ORDER_EN selects age order.
// Revision : 1.0
// ============================================================================

module rs_age_select
    import rs_age_select_pkg::*;
#(
    parameter int RS_SIZE_BIT = `RS_SIZE_BIT,
    parameter int NUM_CDB     = `NUM_CDB,
    parameter int ROB_W       = `ROB_WIDTH_BIT,
    parameter int TYPE_W      = `RS_TYPE_BIT
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    input  logic                      flush,
    input  logic                      inst_valid,
    input  logic [TYPE_W-1:0]         inst_type,
    input  logic [ROB_W-1:0]          inst_rob_id,
    input  logic [DATA_W-1:0]         inst_r1,
    input  logic [DATA_W-1:0]         inst_r2,
    input  logic [ROB_W-1:0]          inst_dep1,
    input  logic [ROB_W-1:0]          inst_dep2,
    input  logic                      inst_has_dep1,
    input  logic                      inst_has_dep2,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]  cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
    output logic                      full,
    output logic [RS_SIZE_BIT:0]      count,
    output logic                      overflow,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [TYPE_W-1:0]         issue_type,
    output logic [ROB_W-1:0]          issue_rob_id,
    output logic [DATA_W-1:0]         issue_r1,
    output logic [DATA_W-1:0]         issue_r2
);

    localparam int DEPTH = 1 << RS_SIZE_BIT;
    localparam int CNT_W = RS_SIZE_BIT + 1;

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  has_dep1_q, has_dep1_d, has_dep2_q, has_dep2_d;
    logic [ROB_W-1:0]  rob_q  [DEPTH];
    logic [ROB_W-1:0]  rob_d  [DEPTH];
    logic [TYPE_W-1:0] type_q [DEPTH];
    logic [TYPE_W-1:0] type_d [DEPTH];
    logic [DATA_W-1:0] r1_q   [DEPTH];
    logic [DATA_W-1:0] r1_d   [DEPTH];
    logic [DATA_W-1:0] r2_q   [DEPTH];
    logic [DATA_W-1:0] r2_d   [DEPTH];
    logic [ROB_W-1:0]  dep1_q [DEPTH];
    logic [ROB_W-1:0]  dep1_d [DEPTH];
    logic [ROB_W-1:0]  dep2_q [DEPTH];
    logic [ROB_W-1:0]  dep2_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    // Lowest-index valid channel carrying the tag wins.
    function automatic cdb_hit_t cdb_lookup(input logic [ROB_W-1:0] tag);
        cdb_hit_t res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_rob_id[k*ROB_W +: ROB_W] == tag)) begin
                res.hit   = 1'b1;
                res.value = cdb_value[k*DATA_W +: DATA_W];
            end
        end
        return res;
    endfunction

    cdb_hit_t          hit1  [DEPTH];
    cdb_hit_t          hit2  [DEPTH];
    logic [DATA_W-1:0] opnd1 [DEPTH];
    logic [DATA_W-1:0] opnd2 [DEPTH];
    logic [DEPTH-1:0]  ready;

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        assign hit1[e]  = cdb_lookup(dep1_q[e]);
        assign hit2[e]  = cdb_lookup(dep2_q[e]);
        assign opnd1[e] = has_dep1_q[e] ? hit1[e].value : r1_q[e];
        assign opnd2[e] = has_dep2_q[e] ? hit2[e].value : r2_q[e];
        assign ready[e] = busy_q[e]
                       && (!has_dep1_q[e] || hit1[e].hit)
                       && (!has_dep2_q[e] || hit2[e].hit);
    end

    cdb_hit_t          ins_hit1, ins_hit2;
    logic [DATA_W-1:0] ins_r1, ins_r2;
    logic              ins_has1, ins_has2;

    assign ins_hit1 = cdb_lookup(inst_dep1);
    assign ins_hit2 = cdb_lookup(inst_dep2);

    always_comb begin
        ins_r1   = inst_r1;
        ins_has1 = 1'b0;
        case (opnd_src(inst_has_dep1, ins_hit1.hit))
            OPND_STORED:  ins_r1 = inst_r1;
            OPND_BYPASS:  ins_r1 = ins_hit1.value;
            default:      ins_has1 = 1'b1;
        endcase
        ins_r2   = inst_r2;
        ins_has2 = 1'b0;
        case (opnd_src(inst_has_dep2, ins_hit2.hit))
            OPND_STORED:  ins_r2 = inst_r2;
            OPND_BYPASS:  ins_r2 = ins_hit2.value;
            default:      ins_has2 = 1'b1;
        endcase
    end

    logic [RS_SIZE_BIT-1:0] ins_idx;
    logic                   ins_found;

    always_comb begin
        ins_idx   = '0;
        ins_found = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (!busy_q[e] && !ins_found) begin
                ins_found = 1'b1;
                ins_idx   = RS_SIZE_BIT'(e);
            end
        end
    end

    logic [DEPTH-1:0]       grant;
    logic [RS_SIZE_BIT-1:0] pick_idx;
    logic                   pick_any;
    logic                   accept;
    logic                   handshake;

`ifdef RS_AGE_ORDER_EN
    logic [DEPTH*DEPTH-1:0] older_q, older_d;
`endif

    rs_pick #(
        .N     (DEPTH),
        .IDX_W (RS_SIZE_BIT)
    ) u_pick (
        .ready (ready),
`ifdef RS_AGE_ORDER_EN
        .older (older_q),
`endif
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign full         = &busy_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign accept       = inst_valid && ins_found;
    assign issue_valid  = pick_any && rdy_in && !flush;
    assign handshake    = issue_valid && issue_ready;
    assign issue_type   = issue_valid ? type_q[pick_idx] : '0;
    assign issue_rob_id = issue_valid ? rob_q[pick_idx]  : '0;
    assign issue_r1     = issue_valid ? opnd1[pick_idx]  : '0;
    assign issue_r2     = issue_valid ? opnd2[pick_idx]  : '0;

    always_comb begin
        busy_d     = busy_q;
        has_dep1_d = has_dep1_q;
        has_dep2_d = has_dep2_q;
        rob_d      = rob_q;
        type_d     = type_q;
        r1_d       = r1_q;
        r2_d       = r2_q;
        dep1_d     = dep1_q;
        dep2_d     = dep2_q;
        count_d    = count_q;
        overflow_d = overflow_q || (inst_valid && full);
        if (flush) begin
            busy_d  = '0;
            count_d = '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (has_dep1_q[e] && hit1[e].hit) begin
                    has_dep1_d[e] = 1'b0;
                    r1_d[e]       = hit1[e].value;
                end
                if (has_dep2_q[e] && hit2[e].hit) begin
                    has_dep2_d[e] = 1'b0;
                    r2_d[e]       = hit2[e].value;
                end
            end
            if (handshake) begin
                busy_d = busy_d & ~grant;
            end
            // The insert slot is free, so it never collides with the issued one.
            if (accept) begin
                busy_d[ins_idx]     = 1'b1;
                rob_d[ins_idx]      = inst_rob_id;
                type_d[ins_idx]     = inst_type;
                r1_d[ins_idx]       = ins_r1;
                r2_d[ins_idx]       = ins_r2;
                has_dep1_d[ins_idx] = ins_has1;
                has_dep2_d[ins_idx] = ins_has2;
                dep1_d[ins_idx]     = inst_dep1;
                dep2_d[ins_idx]     = inst_dep2;
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(handshake);
        end
    end

`ifdef RS_AGE_ORDER_EN
    always_comb begin
        older_d = older_q;
        if (flush) begin
            older_d = '0;
        end else begin
            if (handshake) begin
                for (int e = 0; e < DEPTH; e++) begin
                    older_d[e*DEPTH + int'(pick_idx)] = 1'b0;
                end
            end
            if (accept) begin
                older_d[int'(ins_idx)*DEPTH +: DEPTH] =
                    busy_q & ~(grant & {DEPTH{handshake}});
            end
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            busy_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef RS_AGE_ORDER_EN
            older_q    <= '0;
`endif
        end else if (rdy_in) begin
            busy_q     <= busy_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef RS_AGE_ORDER_EN
            older_q    <= older_d;
`endif
        end
    end

    // Payload is only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            has_dep1_q <= has_dep1_d;
            has_dep2_q <= has_dep2_d;
            rob_q      <= rob_d;
            type_q     <= type_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            dep1_q     <= dep1_d;
            dep2_q     <= dep2_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_age_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_age_select
// Brief    : Self-checking bench for rs_age_select (vector table + issue
//            scoreboard). Follows RS_AGE_ORDER_EN for expected issue order.
// Revision : 1.0
// ============================================================================

module tb_rs_age_select;

    localparam int RSB   = 2;
    localparam int DEPTH = 1 << RSB;

    logic        clk = 1'b0;
    logic        rst_n, rdy, flush;
    logic        inst_valid;
    logic [3:0]  inst_type, inst_rob_id, inst_dep1, inst_dep2;
    logic [31:0] inst_r1, inst_r2;
    logic        inst_has_dep1, inst_has_dep2;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob_id;
    logic [63:0] cdb_value;
    logic        full, overflow, issue_valid, issue_ready;
    logic [2:0]  count;
    logic [3:0]  issue_type, issue_rob_id;
    logic [31:0] issue_r1, issue_r2;

    always #5 clk = ~clk;

    rs_age_select #(
        .RS_SIZE_BIT (RSB),
        .NUM_CDB     (2),
        .ROB_W       (4),
        .TYPE_W      (4)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .rdy_in        (rdy),
        .flush         (flush),
        .inst_valid    (inst_valid),
        .inst_type     (inst_type),
        .inst_rob_id   (inst_rob_id),
        .inst_r1       (inst_r1),
        .inst_r2       (inst_r2),
        .inst_dep1     (inst_dep1),
        .inst_dep2     (inst_dep2),
        .inst_has_dep1 (inst_has_dep1),
        .inst_has_dep2 (inst_has_dep2),
        .cdb_valid     (cdb_valid),
        .cdb_rob_id    (cdb_rob_id),
        .cdb_value     (cdb_value),
        .full          (full),
        .count         (count),
        .overflow      (overflow),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_type    (issue_type),
        .issue_rob_id  (issue_rob_id),
        .issue_r1      (issue_r1),
        .issue_r2      (issue_r2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ins;
        logic [3:0]  rob;
        logic [31:0] r1, r2;
        logic        hd1;
        logic [3:0]  d1;
        logic        hd2;
        logic [3:0]  d2;
        logic [1:0]  cv;
        logic [3:0]  ctag;
        logic [31:0] cval;
        logic        ird;
        logic        e_iv;
        logic [3:0]  e_rob;
        logic [31:0] e_r1, e_r2;
        logic [2:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(logic ins, logic [3:0] rob, logic [31:0] r1, logic [31:0] r2,
                                logic hd1, logic [3:0] d1, logic hd2, logic [3:0] d2,
                                logic [1:0] cv, logic [3:0] ctag, logic [31:0] cval, logic ird,
                                logic e_iv, logic [3:0] e_rob, logic [31:0] e_r1,
                                logic [31:0] e_r2, logic [2:0] e_cnt);
        vec_t v;
        v.ins = ins;  v.rob = rob;  v.r1 = r1;  v.r2 = r2;
        v.hd1 = hd1;  v.d1 = d1;    v.hd2 = hd2; v.d2 = d2;
        v.cv = cv;    v.ctag = ctag; v.cval = cval; v.ird = ird;
        v.e_iv = e_iv; v.e_rob = e_rob; v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_cnt = e_cnt;
        return v;
    endfunction

    // Issue scoreboard: expectations queued at stimulus time, checked on handshake.
    typedef struct {
        logic [3:0]  rob;
        logic [31:0] r1, r2;
    } exp_t;

    exp_t sbq[$];
    exp_t sb_x;
    bit   mon_en = 1'b0;

    function automatic exp_t ex(logic [3:0] rob, logic [31:0] r1, logic [31:0] r2);
        exp_t e;
        e.rob = rob; e.r1 = r1; e.r2 = r2;
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en && issue_valid && issue_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_issue: got rob 0x%0h expected no issue", issue_rob_id);
            end else begin
                sb_x = sbq.pop_front();
                chk("sb_rob", 32'(issue_rob_id), 32'(sb_x.rob));
                chk("sb_r1", issue_r1, sb_x.r1);
                chk("sb_r2", issue_r2, sb_x.r2);
            end
        end
    end

    task automatic clr_inputs();
        inst_valid = 1'b0; inst_type = '0; inst_rob_id = '0;
        inst_r1 = '0; inst_r2 = '0; inst_dep1 = '0; inst_dep2 = '0;
        inst_has_dep1 = 1'b0; inst_has_dep2 = 1'b0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
        flush = 1'b0;
    endtask

    task automatic ins(input logic [3:0] rob, input logic [31:0] r1, input logic [31:0] r2,
                       input logic hd1, input logic [3:0] d1);
        inst_valid = 1'b1; inst_rob_id = rob; inst_type = rob ^ 4'h5;
        inst_r1 = r1; inst_r2 = r2; inst_has_dep1 = hd1; inst_dep1 = d1;
        inst_has_dep2 = 1'b0; inst_dep2 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clr_inputs();
    endtask

    vec_t vecs[14];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 4'd3, 32'd5,      32'd7,     0, 0, 0, 0, 2'b00, 0, 0,         1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0,                     0, 0, 0, 0, 2'b00, 0, 0,         1, 1, 4'd3, 32'd5, 32'd7, 1);
        vecs[2]  = mk(0, 0, 0, 0,                     0, 0, 0, 0, 2'b00, 0, 0,         1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 4'd4, 32'hdead,   32'h22,    1, 9, 0, 0, 2'b00, 0, 0,         1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0,                     0, 0, 0, 0, 2'b00, 0, 0,         1, 0, 0, 0, 0, 1);
        vecs[5]  = mk(0, 0, 0, 0,                     0, 0, 0, 0, 2'b10, 9, 32'h1234,  1, 1, 4'd4, 32'h1234, 32'h22, 1);
        vecs[6]  = mk(0, 0, 0, 0,                     0, 0, 0, 0, 2'b00, 0, 0,         1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 4'd5, 32'd1,      32'hbad,   0, 0, 1, 6, 2'b01, 6, 32'habc,   1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0,                     0, 0, 0, 0, 2'b00, 0, 0,         1, 1, 4'd5, 32'd1, 32'habc, 1);
        vecs[9]  = mk(0, 0, 0, 0,                     0, 0, 0, 0, 2'b00, 0, 0,         1, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 4'd2, 32'd8,      32'd9,     0, 0, 0, 0, 2'b00, 0, 0,         0, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0,                     0, 0, 0, 0, 2'b00, 0, 0,         0, 1, 4'd2, 32'd8, 32'd9, 1);
        vecs[12] = mk(0, 0, 0, 0,                     0, 0, 0, 0, 2'b00, 0, 0,         1, 1, 4'd2, 32'd8, 32'd9, 1);
        vecs[13] = mk(0, 0, 0, 0,                     0, 0, 0, 0, 2'b00, 0, 0,         1, 0, 0, 0, 0, 0);

        clr_inputs();
        rst_n = 1'b0; rdy = 1'b1; issue_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_issue_rob", 32'(issue_rob_id), 0);
        chk("rst_issue_r1", issue_r1, 0);
        chk("rst_issue_r2", issue_r2, 0);
        chk("rst_issue_type", 32'(issue_type), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            inst_valid = vecs[i].ins; inst_rob_id = vecs[i].rob; inst_type = vecs[i].rob ^ 4'h5;
            inst_r1 = vecs[i].r1; inst_r2 = vecs[i].r2;
            inst_has_dep1 = vecs[i].hd1; inst_dep1 = vecs[i].d1;
            inst_has_dep2 = vecs[i].hd2; inst_dep2 = vecs[i].d2;
            cdb_valid = vecs[i].cv;
            cdb_rob_id = {vecs[i].ctag, vecs[i].ctag};
            cdb_value = {vecs[i].cval, vecs[i].cval};
            issue_ready = vecs[i].ird;
            @(negedge clk);
            chk($sformatf("v%0d_issue_valid", i), 32'(issue_valid), 32'(vecs[i].e_iv));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_cnt == 3'(DEPTH)));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 0);
            if (vecs[i].e_iv) begin
                chk($sformatf("v%0d_rob", i), 32'(issue_rob_id), 32'(vecs[i].e_rob));
                chk($sformatf("v%0d_type", i), 32'(issue_type), 32'(vecs[i].e_rob ^ 4'h5));
                chk($sformatf("v%0d_r1", i), issue_r1, vecs[i].e_r1);
                chk($sformatf("v%0d_r2", i), issue_r2, vecs[i].e_r2);
            end
            next_cycle();
        end

        // Age order: A issues alone, D refills A's slot, then B, C, D wake together.
        mon_en = 1'b1;
        issue_ready = 1'b0;
        ins(4'd10, 32'h10, 32'h11, 0, 0); next_cycle();
        ins(4'd11, 32'h0,  32'h21, 1, 1); next_cycle();
        ins(4'd12, 32'h0,  32'h31, 1, 1); next_cycle();
        issue_ready = 1'b1;
        sbq.push_back(ex(4'd10, 32'h10, 32'h11));
        next_cycle();
        issue_ready = 1'b0;
        ins(4'd13, 32'h0, 32'h41, 1, 1); next_cycle();
        @(negedge clk);
        chk("age_count_before_wake", 32'(count), 3);
        issue_ready = 1'b1;
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd1}; cdb_value = {32'h0, 32'h77};
`ifdef RS_AGE_ORDER_EN
        sbq.push_back(ex(4'd11, 32'h77, 32'h21));
        sbq.push_back(ex(4'd12, 32'h77, 32'h31));
        sbq.push_back(ex(4'd13, 32'h77, 32'h41));
`else
        sbq.push_back(ex(4'd13, 32'h77, 32'h41));
        sbq.push_back(ex(4'd11, 32'h77, 32'h21));
        sbq.push_back(ex(4'd12, 32'h77, 32'h31));
`endif
        next_cycle();
        issue_ready = 1'b1; next_cycle();
        issue_ready = 1'b1; next_cycle();
        @(negedge clk);
        chk("age_count_drained", 32'(count), 0);
        chk("age_queue_empty", 32'(sbq.size()), 0);

        // Fill the station, hold back-pressure, then overflow.
        issue_ready = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            ins(4'(k), 32'(k), 32'(2 * k), 0, 0);
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_hold_full", 32'(full), 1);
            chk("full_hold_count", 32'(count), DEPTH);
            next_cycle();
        end
        ins(4'd15, 32'hf, 32'hf, 0, 0);
        @(negedge clk);
        chk("ovf_not_yet", 32'(overflow), 0);
        next_cycle();
        @(negedge clk);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), DEPTH);
        for (int k = 1; k <= DEPTH; k++) sbq.push_back(ex(4'(k), 32'(k), 32'(2 * k)));
        issue_ready = 1'b1;
        repeat (DEPTH) next_cycle();
        @(negedge clk);
        chk("ovf_drain_count", 32'(count), 0);
        chk("ovf_drain_full", 32'(full), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_queue_empty", 32'(sbq.size()), 0);

        // Flush with three ready entries and a concurrent insert.
        issue_ready = 1'b0;
        ins(4'd5, 32'd1, 32'd1, 0, 0); next_cycle();
        ins(4'd6, 32'd2, 32'd2, 0, 0); next_cycle();
        ins(4'd7, 32'd3, 32'd3, 0, 0); next_cycle();
        ins(4'd8, 32'd4, 32'd4, 0, 0);
        flush = 1'b1;
        issue_ready = 1'b1;
        @(negedge clk);
        chk("flush_issue_valid", 32'(issue_valid), 0);
        next_cycle();
        @(negedge clk);
        chk("flush_count", 32'(count), 0);
        chk("flush_issue_valid_after", 32'(issue_valid), 0);
        chk("flush_overflow_kept", 32'(overflow), 1);

        // Global stall: no issue, insert ignored.
        issue_ready = 1'b0;
        ins(4'd9, 32'h99, 32'h98, 0, 0); next_cycle();
        rdy = 1'b0;
        issue_ready = 1'b1;
        ins(4'd10, 32'h1, 32'h1, 0, 0);
        @(negedge clk);
        chk("stall_issue_valid", 32'(issue_valid), 0);
        next_cycle();
        rdy = 1'b1;
        issue_ready = 1'b0;
        @(negedge clk);
        chk("stall_count", 32'(count), 1);
        chk("stall_rob", 32'(issue_rob_id), 9);
        sbq.push_back(ex(4'd9, 32'h99, 32'h98));
        issue_ready = 1'b1;
        next_cycle();
        issue_ready = 1'b0;
        @(negedge clk);
        chk("stall_drain_count", 32'(count), 0);
        chk("stall_queue_empty", 32'(sbq.size()), 0);

        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_overflow", 32'(overflow), 0);
        chk("rst2_count", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
